// File: rtl/mem_arb.sv
// mem_arb: two-master arbiter for the shared memory port. It steers acks back to the owner and aborts with NXM on an ack timeout.
// Define MEM_ARB_RR_EN to select round-robin tie-breaking. When it is undefined, master 0 has fixed priority.
module mem_arb #(
    parameter int PADDR   = 22,
    parameter int WORD    = 36,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PADDR-1:0] m0_addr,
    input  logic [PADDR-1:0] m1_addr,
    input  logic [WORD-1:0]  m0_write_data,
    input  logic [WORD-1:0]  m1_write_data,
    input  logic             m0_read,
    input  logic             m1_read,
    input  logic             m0_write,
    input  logic             m1_write,
    output logic [WORD-1:0]  m0_read_data,
    output logic [WORD-1:0]  m1_read_data,
    output logic             m0_read_ack,
    output logic             m1_read_ack,
    output logic             m0_write_ack,
    output logic             m1_write_ack,
    output logic             m0_nxm,
    output logic             m1_nxm,
    output logic [PADDR-1:0] mem_addr,
    output logic [WORD-1:0]  mem_write_data,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [WORD-1:0]  mem_read_data,
    input  logic             mem_read_ack,
    input  logic             mem_write_ack,
    output logic [1:0]       owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // The timeout fires in the grant cycle whose increment would reach TIMEOUT.
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       req0, req1, pickM1;
    logic       selM1, selRead, selWrite, selReq, memAck;
    logic       readAckFwd, writeAckFwd, nxmPulse;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef MEM_ARB_RR_EN
    logic lastGrant_q, lastGrant_d;

    always_comb begin
        pickM1      = req1;
        lastGrant_d = lastGrant_q;
        if (req0 && req1) begin
            pickM1 = ~lastGrant_q;
        end
        if (state_q == IDLE && (req0 || req1)) begin
            lastGrant_d = pickM1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q <= 1'b1;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end
`else
    assign pickM1 = req1 & ~req0;
`endif

    assign selM1    = (state_q == GRANT1);
    assign selRead  = selM1 ? m1_read : m0_read;
    assign selWrite = selM1 ? m1_write : m0_write;
    assign selReq   = selRead | selWrite;
    assign memAck   = mem_read_ack | mem_write_ack;

    // Ack has priority over a master abort, which in turn suppresses the timeout.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        readAckFwd  = 1'b0;
        writeAckFwd = 1'b0;
        nxmPulse    = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (req0 || req1) begin
                    state_d = pickM1 ? GRANT1 : GRANT0;
                end
            end
            GRANT0, GRANT1: begin
                mem_read    = selRead;
                mem_write   = selWrite;
                readAckFwd  = mem_read_ack;
                writeAckFwd = mem_write_ack;
                if (memAck) begin
                    state_d = IDLE;
                end else if (!selReq) begin
                    state_d = IDLE;
                end else if (count_q == LAST_COUNT) begin
                    nxmPulse  = 1'b1;
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                    state_d   = IDLE;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign mem_addr       = selM1 ? m1_addr : m0_addr;
    assign mem_write_data = selM1 ? m1_write_data : m0_write_data;

    assign m0_read_data = mem_read_data;
    assign m1_read_data = mem_read_data;

    assign m0_read_ack  = readAckFwd & ~selM1;
    assign m1_read_ack  = readAckFwd & selM1;
    assign m0_write_ack = writeAckFwd & ~selM1;
    assign m1_write_ack = writeAckFwd & selM1;
    assign m0_nxm       = nxmPulse & ~selM1;
    assign m1_nxm       = nxmPulse & selM1;

    assign owner = {state_q != IDLE, selM1};

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scenario tests for mem_arb. A scoreboard of expected ack/nxm pulses is consumed by a negedge monitor.
module tb_mem_arb;

    localparam int PADDR    = 22;
    localparam int WORD     = 36;
    localparam int TIMEOUT  = 8;
    localparam int KIND_RD  = 0;
    localparam int KIND_WR  = 1;
    localparam int KIND_NXM = 2;

    typedef struct {
        int              master;
        int              kind;
        logic [WORD-1:0] data;
    } event_t;

    event_t expQ[$];
    int     checks = 0;
    int     errors = 0;

    logic             clk = 1'b0;
    logic             reset;
    logic [PADDR-1:0] m0_addr, m1_addr, mem_addr;
    logic [WORD-1:0]  m0_write_data, m1_write_data, mem_write_data;
    logic             m0_read, m1_read, m0_write, m1_write;
    logic [WORD-1:0]  m0_read_data, m1_read_data, mem_read_data;
    logic             m0_read_ack, m1_read_ack, m0_write_ack, m1_write_ack;
    logic             m0_nxm, m1_nxm;
    logic             mem_read, mem_write, mem_read_ack, mem_write_ack;
    logic [1:0]       owner;

    always #5 clk = ~clk;

    mem_arb #(.PADDR(PADDR), .WORD(WORD), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .m0_addr       (m0_addr),
        .m1_addr       (m1_addr),
        .m0_write_data (m0_write_data),
        .m1_write_data (m1_write_data),
        .m0_read       (m0_read),
        .m1_read       (m1_read),
        .m0_write      (m0_write),
        .m1_write      (m1_write),
        .m0_read_data  (m0_read_data),
        .m1_read_data  (m1_read_data),
        .m0_read_ack   (m0_read_ack),
        .m1_read_ack   (m1_read_ack),
        .m0_write_ack  (m0_write_ack),
        .m1_write_ack  (m1_write_ack),
        .m0_nxm        (m0_nxm),
        .m1_nxm        (m1_nxm),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_read_data (mem_read_data),
        .mem_read_ack  (mem_read_ack),
        .mem_write_ack (mem_write_ack),
        .owner         (owner)
    );

    // Every ack/nxm pulse must match the oldest expected event.
    always @(negedge clk) begin : monitor
        logic [5:0]      pulses;
        logic [WORD-1:0] rd;
        event_t          e;
        pulses = {m1_nxm, m1_write_ack, m1_read_ack, m0_nxm, m0_write_ack, m0_read_ack};
        for (int i = 0; i < 6; i++) begin
            if (pulses[i]) begin
                checks++;
                rd = (i < 3) ? m0_read_data : m1_read_data;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_unexpected: got master %0d kind %0d, required no pulse", i / 3, i % 3);
                end else begin
                    e = expQ.pop_front();
                    if (e.master != i / 3 || e.kind != i % 3 || (e.kind == KIND_RD && rd !== e.data)) begin
                        errors++;
                        $display("[TB] FAIL scoreboard_event: got master %0d kind %0d data %h, required master %0d kind %0d data %h",
                                 i / 3, i % 3, rd, e.master, e.kind, e.data);
                    end
                end
            end
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectEvent(input int master, input int kind, input logic [WORD-1:0] data);
        event_t e;
        e.master = master;
        e.kind   = kind;
        e.data   = data;
        expQ.push_back(e);
    endtask

    task automatic clearInputs();
        m0_addr = '0; m1_addr = '0; m0_write_data = '0; m1_write_data = '0;
        m0_read = 0; m1_read = 0; m0_write = 0; m1_write = 0;
        mem_read_data = '0; mem_read_ack = 0; mem_write_ack = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clearInputs();
        m0_addr  = 22'o7654321;
        m0_read  = 1'b1;
        m1_write = 1'b1;
        repeat (2) waitCycle();
        @(negedge clk);
        checks++;
        if (owner !== 2'b00) begin errors++; $display("[TB] FAIL reset_owner: got %b, required 00", owner); end
        checks++;
        if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes: got %b, required 00", {mem_read, mem_write}); end
        checks++;
        if (mem_addr !== 22'o7654321) begin errors++; $display("[TB] FAIL reset_idle_addr: got %o, required 7654321", mem_addr); end
        waitCycle();
        reset = 1'b0;
        m0_read = 1'b0;
        m1_write = 1'b0;
        @(negedge clk);
        checks++;
        if (owner !== 2'b00) begin errors++; $display("[TB] FAIL reset_release_owner: got %b, required 00", owner); end
    endtask

    task automatic test_single_read();
        logic [WORD-1:0] rdData;
        rdData = 36'o123456701234;
        waitCycle();
        m0_addr = 22'o1000;
        m0_read = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0) begin errors++; $display("[TB] FAIL single_read_request_cycle: mem_read %b, required 0", mem_read); end
        waitCycle();
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL single_read_strobe: mem_read %b, required 1", mem_read); end
        checks++;
        if (mem_addr !== 22'o1000) begin errors++; $display("[TB] FAIL single_read_addr: got %o, required 1000", mem_addr); end
        checks++;
        if (owner !== 2'b10) begin errors++; $display("[TB] FAIL single_read_owner: got %b, required 10", owner); end
        waitCycle();
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL single_read_hold: mem_read %b, required 1", mem_read); end
        waitCycle();
        mem_read_ack  = 1'b1;
        mem_read_data = rdData;
        expectEvent(0, KIND_RD, rdData);
        @(negedge clk);
        checks++;
        if ({m0_read_ack, m1_read_ack} !== 2'b10) begin errors++; $display("[TB] FAIL single_read_ack: got %b, required 10", {m0_read_ack, m1_read_ack}); end
        waitCycle();
        mem_read_ack = 1'b0;
        m0_read      = 1'b0;
        @(negedge clk);
        checks++;
        if (owner !== 2'b00) begin errors++; $display("[TB] FAIL single_read_idle: owner %b, required 00", owner); end
    endtask

    task automatic test_back_to_back();
        logic [PADDR-1:0] a0, a1;
        logic [WORD-1:0]  d0, d1;
        a0 = 22'o2222; a1 = 22'o3333;
        d0 = 36'h0_1234_5678; d1 = 36'h9_8765_4321;
        waitCycle();
        m0_addr = a0; m0_write_data = d0; m0_write = 1'b1;
        m1_addr = a1; m1_read = 1'b1;
        for (int t = 0; t < 3; t++) begin
            int expM;
`ifdef MEM_ARB_RR_EN
            expM = t % 2;
`else
            expM = 0;
`endif
            waitCycle();
            if (expM == 0) begin
                mem_write_ack = 1'b1;
                expectEvent(0, KIND_WR, '0);
            end else begin
                mem_read_ack  = 1'b1;
                mem_read_data = d1;
                expectEvent(1, KIND_RD, d1);
            end
            @(negedge clk);
            checks++;
            if (owner !== {1'b1, expM[0]}) begin errors++; $display("[TB] FAIL b2b_owner[%0d]: got %b, required 1%0d", t, owner, expM); end
            checks++;
            if (mem_addr !== (expM == 0 ? a0 : a1)) begin errors++; $display("[TB] FAIL b2b_addr[%0d]: got %o", t, mem_addr); end
            checks++;
            if ({mem_read, mem_write} !== (expM == 0 ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL b2b_strobes[%0d]: got %b", t, {mem_read, mem_write}); end
            if (expM == 0) begin
                checks++;
                if (mem_write_data !== d0) begin errors++; $display("[TB] FAIL b2b_wdata[%0d]: got %h, required %h", t, mem_write_data, d0); end
            end
            waitCycle();
            mem_write_ack = 1'b0;
            mem_read_ack  = 1'b0;
            if (t == 2) begin
                m0_write = 1'b0;
                m1_read  = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (owner !== 2'b00) begin errors++; $display("[TB] FAIL b2b_gap[%0d]: owner %b, required 00", t, owner); end
        end
    endtask

    task automatic test_timeout();
        waitCycle();
        m1_addr = 22'o4444; m1_write_data = 36'h5_5555_5555; m1_write = 1'b1;
        expectEvent(1, KIND_NXM, '0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            waitCycle();
            @(negedge clk);
            if (i < TIMEOUT) begin
                checks++;
                if (mem_write !== 1'b1) begin errors++; $display("[TB] FAIL timeout_strobe[%0d]: mem_write %b, required 1", i, mem_write); end
                checks++;
                if (m1_nxm !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early_nxm[%0d]: got %b, required 0", i, m1_nxm); end
            end else begin
                checks++;
                if (mem_write !== 1'b0) begin errors++; $display("[TB] FAIL timeout_strobe_forced: mem_write %b, required 0", mem_write); end
                checks++;
                if (m1_nxm !== 1'b1) begin errors++; $display("[TB] FAIL timeout_nxm: got %b, required 1", m1_nxm); end
            end
            checks++;
            if (m1_write_ack !== 1'b0) begin errors++; $display("[TB] FAIL timeout_no_ack[%0d]: got %b, required 0", i, m1_write_ack); end
        end
        waitCycle();
        m1_write = 1'b0;
        @(negedge clk);
        checks++;
        if (owner !== 2'b00) begin errors++; $display("[TB] FAIL timeout_idle: owner %b, required 00", owner); end
    endtask

    task automatic test_abort();
        waitCycle();
        m0_addr = 22'o2000; m0_read = 1'b1;
        waitCycle();
        @(negedge clk);
        checks++;
        if (owner !== 2'b10 || mem_read !== 1'b1) begin errors++; $display("[TB] FAIL abort_grant: owner %b mem_read %b, required 10/1", owner, mem_read); end
        waitCycle();
        m1_addr = 22'o3000; m1_write_data = 36'h6_6666_6666; m1_write = 1'b1;
        @(negedge clk);
        checks++;
        if (owner !== 2'b10 || mem_addr !== 22'o2000 || mem_write !== 1'b0) begin errors++; $display("[TB] FAIL abort_other_ignored: owner %b addr %o write %b", owner, mem_addr, mem_write); end
        waitCycle();
        m0_read = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || m0_read_ack !== 1'b0) begin errors++; $display("[TB] FAIL abort_drop: mem_read %b ack %b, required 0/0", mem_read, m0_read_ack); end
        waitCycle();
        mem_read_ack  = 1'b1;
        mem_read_data = 36'h0_0bad_bad0;
        @(negedge clk);
        checks++;
        if (owner !== 2'b00 || m0_read_ack !== 1'b0) begin errors++; $display("[TB] FAIL abort_late_ack: owner %b ack %b, required 00/0", owner, m0_read_ack); end
        waitCycle();
        mem_read_ack  = 1'b0;
        mem_write_ack = 1'b1;
        expectEvent(1, KIND_WR, '0);
        @(negedge clk);
        checks++;
        if (owner !== 2'b11 || mem_write !== 1'b1 || mem_addr !== 22'o3000) begin errors++; $display("[TB] FAIL abort_next_grant: owner %b write %b addr %o", owner, mem_write, mem_addr); end
        checks++;
        if (m1_write_ack !== 1'b1) begin errors++; $display("[TB] FAIL abort_next_ack: got %b, required 1", m1_write_ack); end
        waitCycle();
        mem_write_ack = 1'b0;
        m1_write      = 1'b0;
        @(negedge clk);
        checks++;
        if (owner !== 2'b00) begin errors++; $display("[TB] FAIL abort_idle: owner %b, required 00", owner); end
    endtask

    task automatic test_reset_mid();
        waitCycle();
        m1_addr = 22'o5000; m1_write = 1'b1;
        waitCycle();
        @(negedge clk);
        checks++;
        if (owner !== 2'b11 || mem_write !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_grant: owner %b write %b, required 11/1", owner, mem_write); end
        waitCycle();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_sync: mem_write %b, required 1 before edge", mem_write); end
        waitCycle();
        reset         = 1'b0;
        m1_write      = 1'b0;
        mem_write_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b0 || owner !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_drop: write %b owner %b, required 0/00", mem_write, owner); end
        checks++;
        if (m1_write_ack !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ack: got %b, required 0", m1_write_ack); end
        waitCycle();
        mem_write_ack = 1'b0;
    endtask

    task automatic test_ack_at_timeout();
        logic [WORD-1:0] rdData;
        rdData = 36'h7_0f0f_0f0f;
        waitCycle();
        m0_addr = 22'o6000; m0_read = 1'b1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            waitCycle();
            if (i == TIMEOUT) begin
                mem_read_ack  = 1'b1;
                mem_read_data = rdData;
                expectEvent(0, KIND_RD, rdData);
            end
            @(negedge clk);
            checks++;
            if (m0_nxm !== 1'b0) begin errors++; $display("[TB] FAIL ackto_nxm[%0d]: got %b, required 0", i, m0_nxm); end
            if (i == TIMEOUT) begin
                checks++;
                if (m0_read_ack !== 1'b1 || mem_read !== 1'b1) begin errors++; $display("[TB] FAIL ackto_ack: ack %b mem_read %b, required 1/1", m0_read_ack, mem_read); end
            end
        end
        waitCycle();
        mem_read_ack = 1'b0;
        m0_read      = 1'b0;
        @(negedge clk);
        checks++;
        if (owner !== 2'b00 || m0_nxm !== 1'b0) begin errors++; $display("[TB] FAIL ackto_idle: owner %b nxm %b, required 00/0", owner, m0_nxm); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_ack_at_timeout();
        repeat (2) waitCycle();
        checks++;
        if (expQ.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_pending: %0d events outstanding, required 0", expQ.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
